// File: rtl/pll_reset_sequencer.sv
// Reset/lock/power-down sequencer for one PLLE2_BASE, clocked by the free-running reference clock.
// Emits a lock-qualified system reset for the PLL-clocked domain; retries on timeout, restarts on loss.
`timescale 1ns/1ps
module pll_reset_sequencer #(
   parameter int unsigned RST_CYCLES   = 16,
   parameter int unsigned LOCK_TIMEOUT = 65536,
   parameter int unsigned LOCK_STABLE  = 256,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked_i,
   input  logic       pwrdwn_req_i,
   output logic       pll_rst_o,
   output logic       pll_pwrdwn_o,
   output logic       sys_rst_o,
   output logic       ready_o,
   output logic       timeout_o,
   output logic       lost_lock_o,
   output logic [7:0] retry_count_o
);

   localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int unsigned MAX_CYC = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STB_DONE = CNT_W'(LOCK_STABLE);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      StResetPll,
      StWaitLock,
      StStable,
      StRun,
      StPowerDown
   } state_t;

   state_t                 r_state;
   state_t                 w_state_d;
   logic [CNT_W-1:0]       r_cnt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_locked_s;
   logic                   w_timeout;
   logic                   w_lost;
   logic                   r_pll_rst;
   logic                   r_pwrdwn;
   logic                   r_sys_rst;
   logic                   r_ready;
   logic                   r_timeout;
   logic                   r_lost;
   logic [7:0]             r_retry;

   // LOCKED is asynchronous to clk; the FSM only ever looks at the last stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked_i};
      end
   end

   assign w_locked_s = r_sync[SYNC_STAGES-1];

   // Power-down beats lock loss, which beats counter expiry.
   always_comb begin
      w_state_d = r_state;
      w_timeout = 1'b0;
      w_lost    = 1'b0;
      if (pwrdwn_req_i) begin
         w_state_d = StPowerDown;
      end else begin
         case (r_state)
            StResetPll: begin
               if (r_cnt == RST_LAST) w_state_d = StWaitLock;
            end
            StWaitLock: begin
               if (w_locked_s) begin
                  w_state_d = StStable;
               end else if (r_cnt == TMO_LAST) begin
                  w_state_d = StResetPll;
                  w_timeout = 1'b1;
               end
            end
            StStable: begin
               if (!w_locked_s) begin
                  w_state_d = StResetPll;
               end else if (r_cnt == STB_DONE) begin
                  w_state_d = StRun;
               end
            end
            StRun: begin
               if (!w_locked_s) begin
                  w_state_d = StResetPll;
                  w_lost    = 1'b1;
               end
            end
            StPowerDown: w_state_d = StResetPll;
            default:     w_state_d = StResetPll;
         endcase
      end
   end

   // Outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= StResetPll;
         r_cnt     <= '0;
         r_pll_rst <= 1'b1;
         r_pwrdwn  <= 1'b0;
         r_sys_rst <= 1'b1;
         r_ready   <= 1'b0;
         r_timeout <= 1'b0;
         r_lost    <= 1'b0;
         r_retry   <= '0;
      end else begin
         r_state <= w_state_d;
         if (w_state_d != r_state) begin
            r_cnt <= '0;
         end else if (r_state inside {StResetPll, StWaitLock, StStable}) begin
            r_cnt <= r_cnt + CNT_ONE;
         end
         r_pll_rst <= (w_state_d == StResetPll) || (w_state_d == StPowerDown);
         r_pwrdwn  <= (w_state_d == StPowerDown);
         r_sys_rst <= (w_state_d != StRun);
         r_ready   <= (w_state_d == StRun);
         r_timeout <= w_timeout;
         r_lost    <= w_lost;
         if (w_timeout && (r_retry != 8'hFF)) begin
            r_retry <= r_retry + 8'd1;
         end
      end
   end

   assign pll_rst_o     = r_pll_rst;
   assign pll_pwrdwn_o  = r_pwrdwn;
   assign sys_rst_o     = r_sys_rst;
   assign ready_o       = r_ready;
   assign timeout_o     = r_timeout;
   assign lost_lock_o   = r_lost;
   assign retry_count_o = r_retry;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: a timed vector table checked through a scoreboard queue,
// followed by hand-written async-reset and retry-saturation sequences.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

   localparam int unsigned RST_CYCLES   = 4;
   localparam int unsigned LOCK_TIMEOUT = 32;
   localparam int unsigned LOCK_STABLE  = 8;
   localparam int unsigned SYNC_STAGES  = 2;
   localparam int unsigned PERIOD_TMO   = RST_CYCLES + LOCK_TIMEOUT;

   logic       clk;
   logic       rst;
   logic       pll_locked_i;
   logic       pwrdwn_req_i;
   logic       pll_rst_o;
   logic       pll_pwrdwn_o;
   logic       sys_rst_o;
   logic       ready_o;
   logic       timeout_o;
   logic       lost_lock_o;
   logic [7:0] retry_count_o;
   logic [13:0] obs;

   // Each record: inputs to drive, edges to advance, outputs required after the last edge.
   typedef struct packed {
      logic        lk;
      logic        pw;
      logic [15:0] n;
      logic [13:0] exp;
   } vec_t;

   typedef struct packed {
      logic [31:0] target;
      logic [13:0] exp;
      logic [15:0] id;
   } sb_t;

   vec_t        tbl[$];
   sb_t         sb[$];
   int unsigned cyc = 0;
   int          n_vec = 0;
   int          n_err = 0;

   pll_reset_sequencer #(
      .RST_CYCLES  (RST_CYCLES),
      .LOCK_TIMEOUT(LOCK_TIMEOUT),
      .LOCK_STABLE (LOCK_STABLE),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .pll_locked_i (pll_locked_i),
      .pwrdwn_req_i (pwrdwn_req_i),
      .pll_rst_o    (pll_rst_o),
      .pll_pwrdwn_o (pll_pwrdwn_o),
      .sys_rst_o    (sys_rst_o),
      .ready_o      (ready_o),
      .timeout_o    (timeout_o),
      .lost_lock_o  (lost_lock_o),
      .retry_count_o(retry_count_o)
   );

   assign obs = {pll_rst_o, pll_pwrdwn_o, sys_rst_o, ready_o, timeout_o, lost_lock_o,
                 retry_count_o};

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Order: pll_rst, pwrdwn, sys_rst, ready, timeout, lost_lock, retry_count.
   function automatic logic [13:0] ex(input logic pr, input logic pd, input logic sr,
                                      input logic rd, input logic to, input logic ll,
                                      input logic [7:0] rc);
      return {pr, pd, sr, rd, to, ll, rc};
   endfunction

   task automatic add(input logic lk, input logic pw, input int n, input logic [13:0] e);
      vec_t v;
      v.lk  = lk;
      v.pw  = pw;
      v.n   = 16'(n);
      v.exp = e;
      tbl.push_back(v);
   endtask

   task automatic check(input string name, input logic [13:0] act, input logic [13:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got {pr,pd,sr,rd,to,ll}=%b retry=%0d, required %b retry=%0d",
                  name, act[13:8], act[7:0], req[13:8], req[7:0]);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      sb_t e;
      rst          = 1'b1;
      pll_locked_i = 1'b0;
      pwrdwn_req_i = 1'b0;

      // Normal bring-up: lock rises 10 cycles after pll_rst falls.
      add(0, 0, 3,  ex(1, 0, 1, 0, 0, 0, 0));
      add(0, 0, 1,  ex(0, 0, 1, 0, 0, 0, 0));
      add(0, 0, 9,  ex(0, 0, 1, 0, 0, 0, 0));
      add(1, 0, 11, ex(0, 0, 1, 0, 0, 0, 0));
      add(1, 0, 1,  ex(0, 0, 0, 1, 0, 0, 0));
      // Lock lost in RUN for 5 cycles.
      add(0, 0, 1,  ex(0, 0, 0, 1, 0, 0, 0));
      add(0, 0, 1,  ex(0, 0, 0, 1, 0, 0, 0));
      add(0, 0, 1,  ex(1, 0, 1, 0, 0, 1, 0));
      add(0, 0, 1,  ex(1, 0, 1, 0, 0, 0, 0));
      add(0, 0, 1,  ex(1, 0, 1, 0, 0, 0, 0));
      add(1, 0, 1,  ex(1, 0, 1, 0, 0, 0, 0));
      add(1, 0, 1,  ex(0, 0, 1, 0, 0, 0, 0));
      add(1, 0, 9,  ex(0, 0, 1, 0, 0, 0, 0));
      add(1, 0, 1,  ex(0, 0, 0, 1, 0, 0, 0));
      // Power-down requested on the edge that sees lock loss.
      add(0, 0, 2,  ex(0, 0, 0, 1, 0, 0, 0));
      add(0, 1, 1,  ex(1, 1, 1, 0, 0, 0, 0));
      add(0, 1, 19, ex(1, 1, 1, 0, 0, 0, 0));
      add(0, 0, 1,  ex(1, 0, 1, 0, 0, 0, 0));
      add(0, 0, 3,  ex(1, 0, 1, 0, 0, 0, 0));
      add(0, 0, 1,  ex(0, 0, 1, 0, 0, 0, 0));
      // One-cycle lock dropout while in STABLE.
      add(1, 0, 5,  ex(0, 0, 1, 0, 0, 0, 0));
      add(0, 0, 1,  ex(0, 0, 1, 0, 0, 0, 0));
      add(1, 0, 1,  ex(0, 0, 1, 0, 0, 0, 0));
      add(1, 0, 1,  ex(1, 0, 1, 0, 0, 0, 0));
      add(1, 0, 3,  ex(1, 0, 1, 0, 0, 0, 0));
      add(1, 0, 1,  ex(0, 0, 1, 0, 0, 0, 0));
      add(1, 0, 9,  ex(0, 0, 1, 0, 0, 0, 0));
      add(1, 0, 1,  ex(0, 0, 0, 1, 0, 0, 0));
      // Three lock timeouts, then lock.
      add(0, 1, 1,  ex(1, 1, 1, 0, 0, 0, 0));
      add(0, 0, 1,  ex(1, 0, 1, 0, 0, 0, 0));
      add(0, 0, 4,  ex(0, 0, 1, 0, 0, 0, 0));
      add(0, 0, 31, ex(0, 0, 1, 0, 0, 0, 0));
      add(0, 0, 1,  ex(1, 0, 1, 0, 1, 0, 1));
      add(0, 0, 1,  ex(1, 0, 1, 0, 0, 0, 1));
      add(0, 0, 2,  ex(1, 0, 1, 0, 0, 0, 1));
      add(0, 0, 1,  ex(0, 0, 1, 0, 0, 0, 1));
      add(0, 0, 31, ex(0, 0, 1, 0, 0, 0, 1));
      add(0, 0, 1,  ex(1, 0, 1, 0, 1, 0, 2));
      add(0, 0, 4,  ex(0, 0, 1, 0, 0, 0, 2));
      add(0, 0, 31, ex(0, 0, 1, 0, 0, 0, 2));
      add(0, 0, 1,  ex(1, 0, 1, 0, 1, 0, 3));
      add(0, 0, 4,  ex(0, 0, 1, 0, 0, 0, 3));
      add(1, 0, 11, ex(0, 0, 1, 0, 0, 0, 3));
      add(1, 0, 1,  ex(0, 0, 0, 1, 0, 0, 3));

      // Scoreboard checker: pops each expectation on the cycle it falls due.
      fork
         forever begin
            @(negedge clk);
            if (sb.size() != 0 && sb[0].target <= cyc) begin
               e = sb.pop_front();
               if (e.target == cyc) begin
                  check($sformatf("vec%0d", e.id), obs, e.exp);
               end else begin
                  n_vec++;
                  n_err++;
                  $display("FAIL vec%0d: sample cycle %0d missed, now %0d", e.id, e.target, cyc);
               end
            end
         end
      join_none

      repeat (3) @(negedge clk);
      check("reset_state", obs, ex(1, 0, 1, 0, 0, 0, 0));
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         sb_t s;
         pll_locked_i = tbl[i].lk;
         pwrdwn_req_i = tbl[i].pw;
         s.target = cyc + 32'(tbl[i].n);
         s.exp    = tbl[i].exp;
         s.id     = 16'(i);
         sb.push_back(s);
         repeat (int'(tbl[i].n)) @(negedge clk);
      end
      for (int k = 0; k < 4; k++) if (sb.size() != 0) @(negedge clk);
      if (sb.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
      end

      // Walk into STABLE via a short power-down, then hit async reset mid-cycle.
      pwrdwn_req_i = 1'b1;
      @(negedge clk);
      check("pd_from_run", obs, ex(1, 1, 1, 0, 0, 0, 3));
      pwrdwn_req_i = 1'b0;
      repeat (RST_CYCLES + 2) @(negedge clk);
      repeat (2) @(negedge clk);
      check("mid_stable", obs, ex(0, 0, 1, 0, 0, 0, 3));
      #2 rst = 1'b1;
      #1 check("async_rst", obs, ex(1, 0, 1, 0, 0, 0, 0));
      pll_locked_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Timeout k lands on edge k*PERIOD_TMO after release.
      repeat (PERIOD_TMO * 255 - 1) @(negedge clk);
      check("retry_254", obs, ex(0, 0, 1, 0, 0, 0, 8'd254));
      @(negedge clk);
      check("retry_255", obs, ex(1, 0, 1, 0, 1, 0, 8'd255));
      repeat (PERIOD_TMO * 5) @(negedge clk);
      check("retry_sat", obs, ex(1, 0, 1, 0, 1, 0, 8'd255));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
